upc_sequencer: RTL and testbench

//   Next-address controller for the 5-bit micro-program counter register.

---
 rtl/upc_sequencer.sv | 133 +++++++++++++
 tb/tb_upc_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/upc_sequencer.sv
// Next-address controller for the micro-program counter, with a call/return stack.
// Latency: load_incr/upc_next are combinational (act on the same edge); state/stack registered.
// Backpressure: stall holds the uPC and freezes state and stack for that cycle.
module upc_sequencer #(
    parameter int              AW        = 5,
    parameter int              DEPTH     = 4,
    parameter logic [AW-1:0]   RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stall,
    input  logic [AW-1:0]              upc,
    input  logic [2:0]                 seq_op,
    input  logic [AW-1:0]              seq_target,
    input  logic                       cond,
    input  logic [AW-1:0]              dispatch_addr,
    output logic                       load_incr,
    output logic [AW-1:0]              upc_next,
    output logic                       busy,
    output logic                       halted,
    output logic                       stack_err,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_BRT  = 3'd2;
    localparam logic [2:0] OP_BRF  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_DISP = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [1:0]    state, state_d;
    logic [DW-1:0] depth;
    logic [AW-1:0] stk [DEPTH];
    logic [AW-1:0] ret_addr;
    logic [IW-1:0] push_idx, top_idx;
    logic          full, empty;
    logic          push, pop, clr, set_err;

    assign ret_addr = upc + AW'(1);
    assign push_idx = IW'(depth);
    assign top_idx  = IW'(depth - DW'(1));
    assign full     = (depth == DW'(DEPTH));
    assign empty    = (depth == '0);

    // The uPC register has no hold mode, so holding means reloading upc itself.
    always_comb begin
        load_incr = 1'b1;
        upc_next  = upc;
        state_d   = state;
        push      = 1'b0;
        pop       = 1'b0;
        clr       = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                upc_next = RESET_VEC;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    case (seq_op)
                        OP_NEXT: load_incr = 1'b0;
                        OP_JUMP: upc_next = seq_target;
                        OP_BRT:  if (cond) upc_next = seq_target; else load_incr = 1'b0;
                        OP_BRF:  if (!cond) upc_next = seq_target; else load_incr = 1'b0;
                        OP_CALL: begin
                            if (full) begin
                                state_d = S_ERR;
                                set_err = 1'b1;
                            end else begin
                                push     = 1'b1;
                                upc_next = seq_target;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                state_d = S_ERR;
                                set_err = 1'b1;
                            end else begin
                                pop      = 1'b1;
                                upc_next = stk[top_idx];
                            end
                        end
                        OP_DISP: upc_next = dispatch_addr;
                        OP_HALT: state_d = S_HALT;
                    endcase
                end
            end
            default: begin
                if (start) begin
                    upc_next = RESET_VEC;
                    state_d  = S_RUN;
                    clr      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            state <= state_d;
            if (clr)        depth <= '0;
            else if (push)  depth <= depth + DW'(1);
            else if (pop)   depth <= depth - DW'(1);
            if (clr)          stack_err <= 1'b0;
            else if (set_err) stack_err <= 1'b1;
        end
    end

    // Entries beyond depth are don't-care, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) stk[push_idx] <= ret_addr;
    end

    assign busy        = (state == S_RUN);
    assign halted      = (state == S_HALT);
    assign stack_depth = depth;
endmodule

// File: tb/tb_upc_sequencer.sv
// Directed bench for upc_sequencer with a behavioural uPC register and a scoreboard.
module tb_upc_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, cond;
    logic [4:0] upc, seq_target, dispatch_addr, upc_next;
    logic [2:0] seq_op, stack_depth;
    logic       load_incr, busy, halted, stack_err;

    typedef struct packed {
        logic [4:0] upc;
        logic [2:0] depth;
        logic       err;
        logic       halt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    logic step_vld = 1'b0;
    int   total = 0;
    int   bad = 0;

    upc_sequencer #(.AW(5), .DEPTH(4), .RESET_VEC(5'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .upc(upc),
        .seq_op(seq_op), .seq_target(seq_target), .cond(cond),
        .dispatch_addr(dispatch_addr), .load_incr(load_incr), .upc_next(upc_next),
        .busy(busy), .halted(halted), .stack_err(stack_err), .stack_depth(stack_depth)
    );

    always #5 clk = ~clk;

    // uPC register: resets to a non-RESET_VEC value so the IDLE load is visible.
    always @(posedge clk or negedge reset) begin
        if (!reset) upc <= 5'h1f;
        else        upc <= load_incr ? upc_next : upc + 5'd1;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every issued step is checked just after the edge it applies to.
    always @(posedge clk) begin
        if (step_vld) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("upc", int'(upc), int'(e.upc));
                chk("depth", int'(stack_depth), int'(e.depth));
                chk("stack_err", int'(stack_err), int'(e.err));
                chk("halted", int'(halted), int'(e.halt));
                chk("busy", int'(busy), int'(e.busy));
            end
        end
    end

    task automatic step(input logic [2:0] op, input logic [4:0] tgt, input logic c,
                        input logic st, input logic sl, input logic [4:0] e_upc,
                        input int e_d, input logic e_err, input logic e_halt,
                        input logic e_busy);
        exp_t e;
        @(negedge clk);
        seq_op = op; seq_target = tgt; cond = c; start = st; stall = sl;
        e.upc = e_upc; e.depth = 3'(e_d); e.err = e_err; e.halt = e_halt; e.busy = e_busy;
        exp_q.push_back(e);
        step_vld = 1'b1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_load_incr"}, int'(load_incr), 1);
        chk({tag, "_upc_next"}, int'(upc_next), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_depth"}, int'(stack_depth), 0);
        chk({tag, "_err"}, int'(stack_err), 0);
    endtask

    localparam logic [2:0] NX = 3'd0, JP = 3'd1, BT = 3'd2, BF = 3'd3,
                           CL = 3'd4, RT = 3'd5, DS = 3'd6, HL = 3'd7;

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; cond = 1'b0;
        seq_op = NX; seq_target = '0; dispatch_addr = 5'd3;
        #1 idle_outputs("reset");
        repeat (2) @(negedge clk);
        idle_outputs("reset_hold");
        reset = 1'b1;

        // 1: idle loads RESET_VEC, start enters RUN, NEXT increments
        step(NX, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        step(NX, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        step(NX, 0, 0, 1, 0,  2, 0, 0, 0, 1);   // start ignored in RUN
        step(NX, 0, 0, 0, 0,  3, 0, 0, 0, 1);
        // 2: jump / branches / dispatch
        step(JP, 5, 0, 0, 0,  5, 0, 0, 0, 1);
        step(JP, 20, 0, 0, 0, 20, 0, 0, 0, 1);
        step(BT, 9, 0, 0, 0,  21, 0, 0, 0, 1);
        step(BF, 9, 0, 0, 0,  9, 0, 0, 0, 1);
        step(BT, 14, 1, 0, 0, 14, 0, 0, 0, 1);
        step(BF, 2, 1, 0, 0,  15, 0, 0, 0, 1);
        step(DS, 0, 0, 0, 0,  3, 0, 0, 0, 1);
        // 3: nested call/return from upc=3
        step(CL, 10, 0, 0, 0, 10, 1, 0, 0, 1);
        step(CL, 16, 0, 0, 0, 16, 2, 0, 0, 1);
        step(RT, 0, 0, 0, 0,  11, 1, 0, 0, 1);
        step(RT, 0, 0, 0, 0,  4, 0, 0, 0, 1);
        // 4: overflow on the fifth call, then restart
        step(CL, 6, 0, 0, 0,  6, 1, 0, 0, 1);
        step(CL, 8, 0, 0, 0,  8, 2, 0, 0, 1);
        step(CL, 9, 0, 0, 0,  9, 3, 0, 0, 1);
        step(CL, 31, 0, 0, 0, 31, 4, 0, 0, 1);
        step(CL, 2, 0, 0, 0,  31, 4, 1, 0, 0);
        step(NX, 0, 0, 0, 0,  31, 4, 1, 0, 0);
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        // wrap at top of address space, CALL at 31 pushes 0
        step(JP, 31, 0, 0, 0, 31, 0, 0, 0, 1);
        step(NX, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        step(JP, 31, 0, 0, 0, 31, 0, 0, 0, 1);
        step(CL, 7, 0, 0, 0,  7, 1, 0, 0, 1);
        step(RT, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        // 5: stall holds, then underflow on RET
        step(JP, 7, 0, 0, 0,  7, 0, 0, 0, 1);
        step(JP, 25, 0, 0, 1, 7, 0, 0, 0, 1);
        step(CL, 25, 0, 0, 1, 7, 0, 0, 0, 1);
        step(JP, 25, 0, 0, 1, 7, 0, 0, 0, 1);
        step(JP, 25, 0, 0, 0, 25, 0, 0, 0, 1);
        step(RT, 0, 0, 0, 0,  25, 0, 1, 0, 0);
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        // 6: reset mid-RUN at depth 2
        step(CL, 10, 0, 0, 0, 10, 1, 0, 0, 1);
        step(CL, 12, 0, 0, 0, 12, 2, 0, 0, 1);
        @(negedge clk);
        step_vld = 1'b0;
        reset = 1'b0;
        #1 idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        step(JP, 12, 0, 0, 0, 12, 0, 0, 0, 1);
        step(HL, 0, 0, 0, 0,  12, 0, 0, 1, 0);
        step(NX, 0, 0, 0, 0,  12, 0, 0, 1, 0);
        step(JP, 3, 0, 0, 1,  12, 0, 0, 1, 0);
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        // HALT with live stack entries: restart clears the stack
        step(CL, 5, 0, 0, 0,  5, 1, 0, 0, 1);
        step(HL, 0, 0, 0, 0,  5, 1, 0, 1, 0);
        step(NX, 0, 0, 1, 0,  0, 0, 0, 0, 1);

        @(negedge clk);
        step_vld = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the end, bad=%0d", bad);
        $fatal(1);
    end
endmodule
